seq_shift_unit: RTL

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/seq_shift_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// Sequential 32-bit shifter: LSL/LSR/ASR/ROR performed one bit per clock.
// A request is captured in IDLE or DONE, shifted in SHIFT, and published in DONE.
module seq_shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); once accepted,
  // busy stays high for n+1 cycles, then done pulses for exactly one cycle with
  // the result already on out. start seen while busy=1 is dropped, not queued.

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] work, work_nxt;
  logic [31:0] out_nxt;
  logic [1:0]  op_q, op_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [5:0]  n_eff;
  logic [31:0] step;

  // Rotates wrap modulo 32; other shifts saturate at 32, which fully flushes the word.
  always_comb begin
    if (op == OP_ROR || b[31:5] == 27'd0) n_eff = {1'b0, b[4:0]};
    else                                  n_eff = 6'd32;
  end

  always_comb begin
    step = work;
    case (op_q)
      OP_LSL:  step = {work[30:0], 1'b0};
      OP_LSR:  step = {1'b0, work[31:1]};
      OP_ASR:  step = {work[31], work[31:1]};
      OP_ROR:  step = {work[0], work[31:1]};
      default: step = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    op_nxt    = op_q;
    cnt_nxt   = cnt;
    out_nxt   = out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          work_nxt  = a;
          op_nxt    = op;
          cnt_nxt   = n_eff;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == 6'd0) begin
          out_nxt   = work;
          state_nxt = DONE;
        end else begin
          work_nxt = step;
          cnt_nxt  = cnt - 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= 32'd0;
      op_q <= OP_LSL;
      cnt  <= 6'd0;
      out  <= 32'd0;
    end else begin
      work <= work_nxt;
      op_q <= op_nxt;
      cnt  <= cnt_nxt;
      out  <= out_nxt;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
